// File: rtl/execute_stage.sv
// Execute stage of the 5-stage MIPS pipeline: forwarding muxes, ALU, dest select, iterative MDU with HI/LO.
// Optional divider is compiled in when MDU_DIV_EN is defined.
module execute_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RD1E,
   input  logic [DATA_WIDTH-1:0] RD2E,
   input  logic [DATA_WIDTH-1:0] SignImmE,
   input  logic [4:0]            RtE,
   input  logic [4:0]            RdE,
   input  logic                  RegDstE,
   input  logic                  ALUSrcE,
   input  logic [2:0]            ALUControlE,
   input  logic [1:0]            ForwardAE,
   input  logic [1:0]            ForwardBE,
   input  logic [DATA_WIDTH-1:0] ALUOutM,
   input  logic [DATA_WIDTH-1:0] ResultW,
   input  logic                  MdStartE,
   input  logic                  MdOpE,
   output logic [DATA_WIDTH-1:0] ALUOutE,
   output logic [DATA_WIDTH-1:0] WriteDataE,
   output logic [4:0]            WriteRegE,
   output logic                  ZeroE,
   output logic                  MdBusyE,
   output logic                  MdDoneE,
   output logic [DATA_WIDTH-1:0] HiE,
   output logic [DATA_WIDTH-1:0] LoE
);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t                r_state;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0] r_opa, r_opb, r_acc, r_hi, r_lo;
   logic                  r_busy, r_done, r_div;

   logic [DATA_WIDTH-1:0] w_srca, w_srcb, w_wd;
   logic [DATA_WIDTH:0]   w_sum;
   logic [DATA_WIDTH-1:0] w_acc_nxt, w_opb_nxt;

   always_comb begin
      case (ForwardAE)
         2'b01:   w_srca = ResultW;
         2'b10:   w_srca = ALUOutM;
         default: w_srca = RD1E;
      endcase
      case (ForwardBE)
         2'b01:   w_wd = ResultW;
         2'b10:   w_wd = ALUOutM;
         default: w_wd = RD2E;
      endcase
      w_srcb = ALUSrcE ? SignImmE : w_wd;
   end

   always_comb begin
      case (ALUControlE)
         3'b000:  ALUOutE = w_srca & w_srcb;
         3'b001:  ALUOutE = w_srca | w_srcb;
         3'b010:  ALUOutE = w_srca + w_srcb;
         3'b110:  ALUOutE = w_srca - w_srcb;
         3'b111:  ALUOutE = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_srca) < $signed(w_srcb))};
         default: ALUOutE = '0;
      endcase
   end

   assign ZeroE      = (ALUOutE == '0);
   assign WriteDataE = w_wd;
   assign WriteRegE  = RegDstE ? RdE : RtE;

`ifdef MDU_DIV_EN
   logic [DATA_WIDTH:0] w_shift, w_diff;
`else
   logic w_unused_op;
   assign w_unused_op = MdOpE;
`endif

   // Multiply: {r_acc, r_opb} is the product register, multiplier bits shift out of r_opb.
   // Divide: r_acc is the partial remainder, quotient bits shift into r_opb.
   always_comb begin
      w_sum     = {1'b0, r_acc} + {1'b0, (r_opb[0] ? r_opa : '0)};
      w_acc_nxt = w_sum[DATA_WIDTH:1];
      w_opb_nxt = {w_sum[0], r_opb[DATA_WIDTH-1:1]};
`ifdef MDU_DIV_EN
      w_shift = {r_acc, r_opb[DATA_WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_opa};
      if (r_div) begin
         if (!w_diff[DATA_WIDTH]) begin
            w_acc_nxt = w_diff[DATA_WIDTH-1:0];
            w_opb_nxt = {r_opb[DATA_WIDTH-2:0], 1'b1};
         end else begin
            w_acc_nxt = w_shift[DATA_WIDTH-1:0];
            w_opb_nxt = {r_opb[DATA_WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_opa   <= '0;
         r_opb   <= '0;
         r_acc   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_div   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (MdStartE) begin
`ifdef MDU_DIV_EN
                  // divisor sits in r_opa, dividend shifts through r_opb
                  r_opa <= MdOpE ? w_wd : w_srca;
                  r_opb <= MdOpE ? w_srca : w_wd;
                  r_div <= MdOpE;
`else
                  r_opa <= w_srca;
                  r_opb <= w_wd;
                  r_div <= 1'b0;
`endif
                  r_acc   <= '0;
                  r_cnt   <= CNT_WIDTH'(DATA_WIDTH);
                  r_busy  <= 1'b1;
                  r_state <= S_ITER;
               end
            end
            S_ITER: begin
               r_acc <= w_acc_nxt;
               r_opb <= w_opb_nxt;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CNT_WIDTH'(1)) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_hi    <= r_acc;
               r_lo    <= r_opb;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign MdBusyE = r_busy;
   assign MdDoneE = r_done;
   assign HiE     = r_hi;
   assign LoE     = r_lo;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU/forwarding, MDU timing, operand capture, reset abort.
module tb_execute_stage;
   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] RD1E, RD2E, SignImmE, ALUOutM, ResultW;
   logic [4:0]  RtE, RdE;
   logic        RegDstE, ALUSrcE, MdStartE, MdOpE;
   logic [2:0]  ALUControlE;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] ALUOutE, WriteDataE, HiE, LoE;
   logic [4:0]  WriteRegE;
   logic        ZeroE, MdBusyE, MdDoneE;

   int n_cmp = 0;
   int n_err = 0;

   execute_stage #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
      .CLK(CLK), .RST(RST), .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
      .RtE(RtE), .RdE(RdE), .RegDstE(RegDstE), .ALUSrcE(ALUSrcE),
      .ALUControlE(ALUControlE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ALUOutM(ALUOutM), .ResultW(ResultW), .MdStartE(MdStartE), .MdOpE(MdOpE),
      .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
      .ZeroE(ZeroE), .MdBusyE(MdBusyE), .MdDoneE(MdDoneE), .HiE(HiE), .LoE(LoE)
   );

   always #5 CLK = ~CLK;

   task automatic test_reset;
      RST = 1'b1; MdStartE = 1'b1; RD1E = 32'd3; RD2E = 32'd4;
      @(negedge CLK); @(negedge CLK);
      n_cmp++; if (MdBusyE !== 1'b0) begin n_err++; $display("FAIL reset_busy got %h want 0", MdBusyE); end
      n_cmp++; if (MdDoneE !== 1'b0) begin n_err++; $display("FAIL reset_done got %h want 0", MdDoneE); end
      n_cmp++; if ({HiE, LoE} !== 64'd0) begin n_err++; $display("FAIL reset_hilo got %h want 0", {HiE, LoE}); end
      RST = 1'b0; MdStartE = 1'b0;
      @(negedge CLK);
      n_cmp++; if (MdBusyE !== 1'b0) begin n_err++; $display("FAIL start_with_rst_ignored got %h want 0", MdBusyE); end
   endtask

   task automatic test_alu_forward;
      RD1E = 32'd5; ResultW = 32'd7; ForwardAE = 2'b01; ForwardBE = 2'b00; RD2E = 32'd3;
      ALUControlE = 3'b010; ALUSrcE = 1'b0; #1;
      n_cmp++; if (ALUOutE !== 32'd10) begin n_err++; $display("FAIL fwd_add got %h want a", ALUOutE); end
      n_cmp++; if (WriteDataE !== 32'd3) begin n_err++; $display("FAIL fwd_wd got %h want 3", WriteDataE); end
      n_cmp++; if (ZeroE !== 1'b0) begin n_err++; $display("FAIL fwd_zero got %h want 0", ZeroE); end
      ALUOutM = 32'd20; ForwardAE = 2'b10; ForwardBE = 2'b01; #1;
      n_cmp++; if (ALUOutE !== 32'd27) begin n_err++; $display("FAIL fwd_m_w got %h want 1b", ALUOutE); end
      ForwardAE = 2'b11; ForwardBE = 2'b10; SignImmE = 32'd100; ALUSrcE = 1'b1; #1;
      n_cmp++; if (ALUOutE !== 32'd105) begin n_err++; $display("FAIL fwd11_imm got %h want 69", ALUOutE); end
      n_cmp++; if (WriteDataE !== 32'd20) begin n_err++; $display("FAIL wd_before_alusrc got %h want 14", WriteDataE); end
   endtask

   task automatic test_alu_ops;
      logic [2:0]  ctl [8];
      logic [31:0] exp [8];
      ctl = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
      exp = '{32'h00F0_0034, 32'hFFF0_12FF, 32'h00E0_1333, 32'hE100_1135,
              32'd1, 32'd0, 32'd0, 32'd0};
      RD1E = 32'hF0F0_1234; RD2E = 32'h0FF0_00FF; ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcE = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ALUControlE = ctl[i]; #1;
         n_cmp++; if (ALUOutE !== exp[i]) begin n_err++; $display("FAIL alu_op%0b got %h want %h", ctl[i], ALUOutE, exp[i]); end
      end
      RD1E = 32'hFFFF_FFFF; SignImmE = 32'd1; ALUSrcE = 1'b1; ALUControlE = 3'b111; #1;
      n_cmp++; if (ALUOutE !== 32'd1) begin n_err++; $display("FAIL slt_neg got %h want 1", ALUOutE); end
      ALUControlE = 3'b010; #1;
      n_cmp++; if (ALUOutE !== 32'd0 || ZeroE !== 1'b1) begin n_err++; $display("FAIL add_wrap got %h/%h want 0/1", ALUOutE, ZeroE); end
      RD1E = 32'd4; RD2E = 32'd4; ALUSrcE = 1'b0; ALUControlE = 3'b110; #1;
      n_cmp++; if (ALUOutE !== 32'd0 || ZeroE !== 1'b1) begin n_err++; $display("FAIL sub_zero got %h/%h want 0/1", ALUOutE, ZeroE); end
      RtE = 5'd9; RdE = 5'd22; RegDstE = 1'b1; #1;
      n_cmp++; if (WriteRegE !== 5'd22) begin n_err++; $display("FAIL regdst_rd got %0d want 22", WriteRegE); end
      RegDstE = 1'b0; #1;
      n_cmp++; if (WriteRegE !== 5'd9) begin n_err++; $display("FAIL regdst_rt got %0d want 9", WriteRegE); end
   endtask

   task automatic test_multiply;
      int nbusy, ndone, done_at;
      nbusy = 0; ndone = 0; done_at = -1;
      @(negedge CLK);
      RD1E = 32'hFFFF_FFFF; RD2E = 32'd2; ForwardAE = 2'b00; ForwardBE = 2'b00; MdOpE = 1'b0; MdStartE = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (MdBusyE) nbusy++;
         if (MdDoneE) begin ndone++; done_at = i; end
         if (i == 32) begin
            n_cmp++; if (LoE !== 32'd0) begin n_err++; $display("FAIL mul_lo_early got %h want 0", LoE); end
         end
         if (i == 33) begin
            n_cmp++; if (HiE !== 32'd1) begin n_err++; $display("FAIL mul_hi got %h want 1", HiE); end
            n_cmp++; if (LoE !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mul_lo got %h want fffffffe", LoE); end
         end
         MdStartE = (i == 5);
         if (i == 5) RD1E = 32'd3;
      end
      n_cmp++; if (nbusy != 32) begin n_err++; $display("FAIL mul_busy_cycles got %0d want 32", nbusy); end
      n_cmp++; if (ndone != 1 || done_at != 32) begin n_err++; $display("FAIL mul_done_pulse got %0d@%0d want 1@32", ndone, done_at); end
   endtask

   task automatic test_capture;
      RD1E = 32'd6; RD2E = 32'd7; ForwardAE = 2'b00; ForwardBE = 2'b00; MdOpE = 1'b0; MdStartE = 1'b1;
      @(negedge CLK);
      MdStartE = 1'b0;
      repeat (4) @(negedge CLK);
      RD1E = 32'd100; ALUOutM = 32'd55; ForwardAE = 2'b10; RD2E = 32'd9;
      repeat (35) @(negedge CLK);
      n_cmp++; if (LoE !== 32'd42 || HiE !== 32'd0) begin n_err++; $display("FAIL capture got %h:%h want 0:2a", HiE, LoE); end
   endtask

   task automatic test_reset_midop;
      int ndone;
      ndone = 0;
      RD1E = 32'hFFFF_FFFF; RD2E = 32'd2; ForwardAE = 2'b00; ForwardBE = 2'b00; MdStartE = 1'b1;
      @(negedge CLK);
      MdStartE = 1'b0;
      repeat (9) @(negedge CLK);
      n_cmp++; if (MdBusyE !== 1'b1) begin n_err++; $display("FAIL midop_busy got %h want 1", MdBusyE); end
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      n_cmp++; if (MdBusyE !== 1'b0) begin n_err++; $display("FAIL abort_busy got %h want 0", MdBusyE); end
      n_cmp++; if ({HiE, LoE} !== 64'd0) begin n_err++; $display("FAIL abort_hilo got %h want 0", {HiE, LoE}); end
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (MdDoneE || MdBusyE) ndone++;
      end
      n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL abort_no_done got %0d want 0", ndone); end
   endtask

`ifdef MDU_DIV_EN
   task automatic test_divide;
      RD1E = 32'd100; RD2E = 32'd7; ForwardAE = 2'b00; ForwardBE = 2'b00; MdOpE = 1'b1; MdStartE = 1'b1;
      @(negedge CLK);
      MdStartE = 1'b0;
      repeat (34) @(negedge CLK);
      n_cmp++; if (LoE !== 32'd14 || HiE !== 32'd2) begin n_err++; $display("FAIL div_100_7 got %h:%h want 2:e", HiE, LoE); end
      RD1E = 32'd9; RD2E = 32'd0; MdStartE = 1'b1;
      @(negedge CLK);
      MdStartE = 1'b0;
      repeat (34) @(negedge CLK);
      n_cmp++; if (LoE !== 32'hFFFF_FFFF || HiE !== 32'd9) begin n_err++; $display("FAIL div_by_zero got %h:%h want 9:ffffffff", HiE, LoE); end
      MdOpE = 1'b0;
   endtask
`else
   task automatic test_op_ignored;
      RD1E = 32'd6; RD2E = 32'd7; ForwardAE = 2'b00; ForwardBE = 2'b00; MdOpE = 1'b1; MdStartE = 1'b1;
      @(negedge CLK);
      MdStartE = 1'b0;
      repeat (34) @(negedge CLK);
      n_cmp++; if (LoE !== 32'd42 || HiE !== 32'd0) begin n_err++; $display("FAIL mdop_ignored got %h:%h want 0:2a", HiE, LoE); end
      MdOpE = 1'b0;
   endtask
`endif

   initial begin
      RST = 1'b1; RD1E = '0; RD2E = '0; SignImmE = '0; ALUOutM = '0; ResultW = '0;
      RtE = '0; RdE = '0; RegDstE = 1'b0; ALUSrcE = 1'b0; MdStartE = 1'b0; MdOpE = 1'b0;
      ALUControlE = 3'b000; ForwardAE = 2'b00; ForwardBE = 2'b00;
      test_reset();
      test_alu_forward();
      test_alu_ops();
      test_multiply();
      test_capture();
      test_reset_midop();
`ifdef MDU_DIV_EN
      test_divide();
`else
      test_op_ignored();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute-stage datapath of the 5-stage MIPS pipeline.
- Consumes the outputs of the decode/execute pipeline register and drives the execute/memory register.
- Contains forwarding muxes, ALU, destination-register select and an iterative multiply unit with HI/LO registers.
- The multiply unit raises a busy flag that the hazard unit uses to stall fetch/decode and clear the decode/execute register.

Parameters:
- DATA_WIDTH, 32, datapath width.
- CNT_WIDTH, 6, iteration counter width (must hold DATA_WIDTH).

Ports:
- CLK  input  1  pipeline clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- RD1E  input  DATA_WIDTH  register-file operand A from the execute register.
- RD2E  input  DATA_WIDTH  register-file operand B from the execute register.
- SignImmE  input  DATA_WIDTH  sign-extended immediate.
- RtE  input  5  rt field.
- RdE  input  5  rd field.
- RegDstE  input  1  1 selects RdE as destination, 0 selects RtE.
- ALUSrcE  input  1  1 selects SignImmE as SrcB.
- ALUControlE  input  3  ALU operation.
- ForwardAE  input  2  00 RD1E, 01 ResultW, 10 ALUOutM, 11 RD1E.
- ForwardBE  input  2  same encoding, applied to RD2E.
- ALUOutM  input  DATA_WIDTH  forwarded value from the memory stage.
- ResultW  input  DATA_WIDTH  forwarded value from the writeback stage.
- MdStartE  input  1  start multiply (or divide) with the current forwarded operands.
- MdOpE  input  1  0 = multiply, 1 = divide (divide only when the macro is defined).
- ALUOutE  output  DATA_WIDTH  ALU result, combinational.
- WriteDataE  output  DATA_WIDTH  forwarded SrcB before the ALUSrc mux (store data).
- WriteRegE  output  5  destination register.
- ZeroE  output  1  ALUOutE == 0.
- MdBusyE  output  1  multiply/divide unit is in ITER; stall request to the hazard unit.
- MdDoneE  output  1  one-cycle pulse when HI/LO are updated.
- HiE  output  DATA_WIDTH  HI register.
- LoE  output  DATA_WIDTH  LO register.

Behaviour:
- Combinational path:
  - SrcA = ForwardAE mux; WriteDataE = ForwardBE mux.
  - SrcB = ALUSrcE ? SignImmE : WriteDataE.
  - WriteRegE = RegDstE ? RdE : RtE.
- ALUControlE encoding:
  - 000 AND, 001 OR, 010 ADD (wrap modulo 2^DATA_WIDTH, no overflow flag).
  - 110 SUB (wrap); 111 SLT (signed compare, result 1 or 0).
  - 011, 100, 101 produce 0.
- MDU state machine, states IDLE, ITER, DONE:
  - IDLE: MdStartE=1 latches SrcA/WriteDataE into the operand registers, clears the accumulator, loads count = DATA_WIDTH, goes to ITER.
  - ITER: one shift-add step per cycle, count decrements. Move to DONE in the cycle after count reaches 1 is processed, i.e. exactly DATA_WIDTH cycles in ITER.
  - DONE: {HiE, LoE} <= 64-bit unsigned product; MdDoneE=1 for this single cycle; next state IDLE.
  - Latency: start sampled at edge N, HI/LO visible after edge N+DATA_WIDTH+1 (33 for default).
- MdBusyE = (state == ITER). It is low in IDLE and DONE.
- MdStartE is ignored in ITER and DONE. A start in IDLE on the same cycle as RST is ignored.
- HI/LO hold their value except in DONE. The ALU path is fully independent of MDU state.
- RST:
  - Forces IDLE and zeroes count, operands, accumulator, HiE, LoE.
  - MdBusyE=0, MdDoneE=0.
  - Reset mid-ITER aborts the operation; HI/LO read 0 afterwards.
- Operands are captured once at start; later forwarding changes do not affect the result.

Optional Feature:
- Macro: MDU_DIV_EN.
- Defined:
  - MdOpE=1 at start runs unsigned restoring division, DATA_WIDTH iterations, same timing as multiply.
  - LoE = quotient, HiE = remainder.
  - Divide by zero: LoE = all ones, HiE = dividend.
- Undefined:
  - MdOpE is ignored; every start performs a multiply.
  - No divider logic is synthesized.

Test Plan:
- ALU/forwarding: RD1E=5, ResultW=7, ForwardAE=01, ForwardBE=00, RD2E=3, ALUControlE=010, ALUSrcE=0 -> ALUOutE=10, WriteDataE=3, ZeroE=0.
- SLT/SUB and ALUSrc: SrcA=0xFFFFFFFF, SignImmE=1, ALUSrcE=1, ALUControlE=111 -> ALUOutE=1. ALUControlE=110 with SrcA=SrcB=4 -> ALUOutE=0, ZeroE=1. RegDstE toggle selects RdE/RtE.
- Multiply: start with 0xFFFFFFFF x 2 -> MdBusyE high exactly 32 cycles, MdDoneE pulses once, then HiE=0x00000001, LoE=0xFFFFFFFE. A second start during ITER is ignored.
- Operand capture: change ForwardAE/RD1E mid-ITER after starting 6x7 -> LoE=42, HiE=0.
- Reset mid-op: RST high at ITER cycle 10 -> next cycle IDLE, MdBusyE=0, HiE=LoE=0, no MdDoneE pulse.
- MDU_DIV_EN builds: 100/7 -> LoE=14, HiE=2. 9/0 -> LoE=0xFFFFFFFF, HiE=9.
